ysyx_24100012_ifu_pc: RTL and testbench
=======================================

# ysyx_24100012_ifu_pc

Instruction-fetch and PC-update unit of the ysyx_24100012 core. It consumes the branch comparator's `PCSel` decision and the target address from the execute stage. It holds the architectural PC, fetches instructions over a valid/ready memory port, and hands each instruction to decode. It runs a strictly serial, multi-cycle loop: fetch, issue, then wait for the commit that selects the next PC.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, PC and memory address width
- `DATA_WIDTH`, 32, instruction width
- `RESET_PC`, 32'h8000_0000, PC loaded on reset

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `PCSel`  in  1  1 = take `pc_target`, 0 = sequential; sampled only on a commit handshake
- `pc_target`  in  ADDR_WIDTH  branch/jump target from execute
- `commit_valid`  in  1  execute has finished the issued instruction; `PCSel`/`pc_target` valid
- `commit_ready`  out  1  unit accepts a commit this cycle
- `imem_req_valid`  out  1  fetch request
- `imem_req_addr`  out  ADDR_WIDTH  fetch address, equals `pc`
- `imem_req_ready`  in  1  memory accepts the request
- `imem_resp_valid`  in  1  fetch data returned
- `imem_resp_data`  in  DATA_WIDTH  instruction word
- `imem_resp_err`  in  1  access fault, qualified by `imem_resp_valid`
- `inst_valid`  out  1  instruction available to decode
- `inst`  out  DATA_WIDTH  latched instruction
- `inst_pc`  out  ADDR_WIDTH  PC of `inst`
- `inst_ready`  in  1  decode accepts `inst`
- `pc`  out  ADDR_WIDTH  current PC register
- `fetch_err`  out  1  sticky error flag

## Operation
- FSM states: REQ, WAIT, ISSUE, COMMIT, ERR.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`, both held stable until `imem_req_ready`. On handshake, go to WAIT.
- WAIT: ignore inputs until `imem_resp_valid`.
  - If `imem_resp_err`=1, go to ERR.
  - Otherwise latch `inst`←`imem_resp_data` and `inst_pc`←`pc`, then go to ISSUE.
- ISSUE: `inst_valid`=1; `inst` and `inst_pc` stay stable. On `inst_ready`, go to COMMIT.
- COMMIT: `commit_ready`=1. On `commit_valid`, compute next = `PCSel` ? {`pc_target`[ADDR_WIDTH-1:1],1'b0} : `pc`+4.
  - If next[1]=1 (misaligned), load `pc`←next and go to ERR.
  - Otherwise load `pc`←next and go to REQ.
- ERR: all valids/readies 0, `fetch_err`=1. Leave only via `rst`.
- `pc`+4 wraps modulo 2^ADDR_WIDTH with no flag.
- `PCSel` and `pc_target` are don't-care outside a commit handshake.
- `imem_resp_valid` outside WAIT is ignored. `commit_valid` outside COMMIT is ignored.
- Exactly one instruction is in flight; no prefetch, no speculation.

## Timing
- Reset values:
  - state=REQ, `pc`=`inst_pc`=RESET_PC, `inst`=0, `fetch_err`=0.
  - `inst_valid`=`commit_ready`=0.
  - `imem_req_valid`=1 from the first cycle after reset release.
- `rst` asserted in any state, including mid-handshake: next cycle is REQ with reset values. The memory shares `rst` and drops any outstanding response.
- All outputs come from registers or decode of the state register only. There is no combinational input-to-output path.
- Minimum loop is 4 cycles per instruction: REQ handshake, response in the following cycle, ISSUE accepted same cycle, COMMIT accepted same cycle.
- Each stall (`imem_req_ready`=0, late response, `inst_ready`=0, `commit_valid`=0) adds one cycle per stalled cycle. Outputs hold during stalls.
- New `pc` is visible the cycle after the commit handshake, together with `imem_req_valid`=1.

## Test plan
- Reset, then memory always ready, response 1 cycle after request with 32'h00000013, `PCSel`=0 each commit -> fetch addresses 0x80000000, 0x80000004, 0x80000008; one `inst_valid` pulse per 4 cycles; `inst_pc` matches.
- Commit with `PCSel`=1, `pc_target`=0x80000101 -> next request address 0x80000100 (bit0 cleared); `fetch_err`=0.
- Commit with `PCSel`=1, `pc_target`=0x80000102 -> `pc`=0x80000102, state ERR, `fetch_err`=1, no further requests until `rst`.
- `imem_req_ready` low 3 cycles, response delayed 2 cycles, `inst_ready` low 2 cycles -> address and `inst` held stable throughout; stray `commit_valid`/`imem_resp_valid` pulses during stalls change nothing.
- `pc`=0xFFFFFFFC with `PCSel`=0 -> next fetch 0x00000000. Response with `imem_resp_err`=1 -> `fetch_err`=1, `inst_valid` never asserted.
- `rst` asserted in WAIT and again in COMMIT -> next cycle `pc`=0x80000000, `imem_req_valid`=1, `inst_valid`=0, `fetch_err`=0.

Source files
------------

// File: rtl/ysyx_24100012_ifu_pc_if.sv
// Bus bundle between the fetch/PC unit and its neighbours: commit port from
// execute, instruction memory request/response, and the decode hand-off.
// master = the fetch unit, slave = the surrounding pipeline and memory.
interface ysyx_24100012_ifu_pc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  PCSel;
  logic [ADDR_WIDTH-1:0] pc_target;
  logic                  commit_valid;
  logic                  commit_ready;

  logic                  imem_req_valid;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_resp_valid;
  logic [DATA_WIDTH-1:0] imem_resp_data;
  logic                  imem_resp_err;

  logic                  inst_valid;
  logic [DATA_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  inst_ready;

  logic [ADDR_WIDTH-1:0] pc;
  logic                  fetch_err;

  modport master (
    input  PCSel, pc_target, commit_valid,
    output commit_ready,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    output inst_valid, inst, inst_pc,
    input  inst_ready,
    output pc, fetch_err
  );

  modport slave (
    output PCSel, pc_target, commit_valid,
    input  commit_ready,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
    input  inst_valid, inst, inst_pc,
    output inst_ready,
    input  pc, fetch_err
  );
endinterface

// File: rtl/ysyx_24100012_ifu_pc.sv
// Instruction fetch and PC update unit: one instruction in flight at a time,
// looping request -> response -> issue to decode -> commit from execute.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_REQ    | fetch request for pc is presented to memory
// S_WAIT   | request accepted, waiting for the instruction word
// S_ISSUE  | latched instruction offered to decode
// S_COMMIT | waiting for execute to report the next-PC decision
// S_ERR    | access fault or misaligned PC; parked until reset
module ysyx_24100012_ifu_pc #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000)
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_24100012_ifu_pc_if.master      bus
);

  typedef enum logic [2:0] {
    S_REQ    = 3'd0,
    S_WAIT   = 3'd1,
    S_ISSUE  = 3'd2,
    S_COMMIT = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] next_pc;

  // Next-state and datapath update; every output is a pure decode of the
  // registers, so inputs only ever steer the _d values here.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    // Jump targets drop bit 0; a set bit 1 survives and is trapped below.
    next_pc   = bus.PCSel ? (bus.pc_target & ALIGN_MASK) : (pc_q + PC_STEP);

    case (state_q)
      S_REQ: begin
        if (bus.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_resp_valid) begin
          if (bus.imem_resp_err) begin
            state_d = S_ERR;
          end else begin
            inst_d    = bus.imem_resp_data;
            inst_pc_d = pc_q;
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (bus.inst_ready) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        if (bus.commit_valid) begin
          pc_d    = next_pc;
          state_d = next_pc[1] ? S_ERR : S_REQ;
        end
      end
      default: state_d = S_ERR;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      inst_pc_q <= RESET_PC;
      inst_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_pc_q <= inst_pc_d;
      inst_q    <= inst_d;
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (state_q == S_ISSUE);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.commit_ready   = (state_q == S_COMMIT);
  assign bus.pc             = pc_q;
  assign bus.fetch_err      = (state_q == S_ERR);

endmodule

// File: tb/tb_ysyx_24100012_ifu_pc.sv
// Scoreboard bench for the fetch/PC unit: the stimulus process plays memory,
// decode and execute, predicts fetch addresses and issued instructions from
// the architectural rules, and a negedge monitor checks what the DUT shows.
module tb_ysyx_24100012_ifu_pc;
  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_24100012_ifu_pc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ysyx_24100012_ifu_pc #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] addr_q[$];
  logic [63:0] inst_q[$];
  bit          force_sel_q[$];
  logic [31:0] force_tgt_q[$];

  logic [31:0] model_pc;
  bit          model_err;
  int          err_age;
  bit          pending;
  int          delay_cnt;

  int p_req_rdy = 100, p_inst_rdy = 100, p_commit = 100;
  int max_delay = 0, p_err = 0, p_stray = 0;
  bit fast_mode = 1'b0;

  int cyc = 0;
  int last_inst = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_fail(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  function automatic bit roll(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  // One cycle of environment behaviour, driven 1ns after the rising edge.
  task automatic cycle();
    logic [31:0] tgt;
    logic [31:0] nxt;
    bus.imem_req_ready  = roll(p_req_rdy);
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_err   = roll(50);
    bus.imem_resp_data  = $urandom;
    if (pending) begin
      if (delay_cnt == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_err   = roll(p_err);
        pending = 1'b0;
        if (!model_err) begin
          if (bus.imem_resp_err) model_err = 1'b1;
          else inst_q.push_back({bus.imem_resp_data, model_pc});
        end
      end else begin
        delay_cnt--;
      end
    end else begin
      bus.imem_resp_valid = roll(p_stray);
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      pending   = 1'b1;
      delay_cnt = $urandom_range(max_delay);
    end

    bus.inst_ready   = roll(p_inst_rdy);
    bus.commit_valid = roll(p_commit);
    bus.PCSel        = roll(50);
    tgt              = $urandom;
    if (roll(85)) tgt[1] = 1'b0;
    bus.pc_target    = tgt;
    if (bus.commit_ready && bus.commit_valid && !model_err) begin
      if (force_sel_q.size() > 0) begin
        bus.PCSel     = force_sel_q.pop_front();
        bus.pc_target = force_tgt_q.pop_front();
      end
      if (bus.PCSel) nxt = {bus.pc_target[31:1], 1'b0};
      else           nxt = model_pc + 32'd4;
      model_pc = nxt;
      if (nxt[1]) model_err = 1'b1;
      else        addr_q.push_back(nxt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.inst_ready      = 1'b0;
    bus.commit_valid    = 1'b0;
    pending = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    addr_q.delete();
    inst_q.delete();
    force_sel_q.delete();
    force_tgt_q.delete();
    model_pc  = RST_PC;
    model_err = 1'b0;
    err_age   = 0;
    addr_q.push_back(RST_PC);
    chk("rst_pc",           bus.pc,             RST_PC);
    chk("rst_inst_pc",      bus.inst_pc,        RST_PC);
    chk("rst_inst",         bus.inst,           '0);
    chk("rst_req_valid",    bus.imem_req_valid, 1'b1);
    chk("rst_req_addr",     bus.imem_req_addr,  RST_PC);
    chk("rst_inst_valid",   bus.inst_valid,     1'b0);
    chk("rst_commit_ready", bus.commit_ready,   1'b0);
    chk("rst_fetch_err",    bus.fetch_err,      1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (model_err) begin
        err_age++;
        if (err_age == 3) begin
          chk("err_flag",         bus.fetch_err,      1'b1);
          chk("err_req_valid",    bus.imem_req_valid, 1'b0);
          chk("err_inst_valid",   bus.inst_valid,     1'b0);
          chk("err_commit_ready", bus.commit_ready,   1'b0);
          chk("err_pc",           bus.pc,             model_pc);
          do_reset(1);
        end
      end
    end
  endtask

  // Monitor: compare presented request / instruction with the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (rst || !fast_mode) last_inst = -1;
    if (!rst) begin
      if (bus.imem_req_valid) begin
        if (addr_q.size() == 0) chk_fail("unexpected_req", bus.imem_req_addr);
        else begin
          chk("req_addr", bus.imem_req_addr, addr_q[0]);
          if (bus.imem_req_ready) void'(addr_q.pop_front());
        end
      end
      if (bus.inst_valid) begin
        if (inst_q.size() == 0) chk_fail("unexpected_inst", bus.inst);
        else begin
          chk("inst",    bus.inst,    inst_q[0][63:32]);
          chk("inst_pc", bus.inst_pc, inst_q[0][31:0]);
          if (bus.inst_ready) begin
            void'(inst_q.pop_front());
            if (fast_mode) begin
              if (last_inst >= 0) chk("inst_interval", cyc - last_inst, 4);
              last_inst = cyc;
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1;
    bus.PCSel = 1'b0;
    bus.pc_target = '0;
    bus.commit_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    bus.imem_resp_err = 1'b0;
    bus.inst_ready = 1'b0;
    pending = 1'b0;
    do_reset(2);

    // Back-to-back sequential fetches at full speed.
    fast_mode = 1'b1;
    repeat (4) begin force_sel_q.push_back(1'b0); force_tgt_q.push_back('0); end
    run(14);

    // Taken branch with bit 0 set in the target.
    force_sel_q.delete(); force_tgt_q.delete();
    force_sel_q.push_back(1'b1); force_tgt_q.push_back(32'h8000_0101);
    force_sel_q.push_back(1'b0); force_tgt_q.push_back('0);
    run(10);
    chk("branch_no_err", bus.fetch_err, 1'b0);

    // Sequential wrap from the top of the address space.
    force_sel_q.delete(); force_tgt_q.delete();
    force_sel_q.push_back(1'b1); force_tgt_q.push_back(32'hFFFF_FFFC);
    force_sel_q.push_back(1'b0); force_tgt_q.push_back('0);
    force_sel_q.push_back(1'b0); force_tgt_q.push_back('0);
    run(14);
    fast_mode = 1'b0;

    // Misaligned jump target parks the unit until reset.
    force_sel_q.delete(); force_tgt_q.delete();
    force_sel_q.push_back(1'b1); force_tgt_q.push_back(32'h8000_0102);
    run(12);

    // Stalls on every handshake with stray response / commit pulses.
    p_req_rdy = 40; p_inst_rdy = 40; p_commit = 40; max_delay = 3; p_stray = 30;
    run(200);

    // Access fault response.
    p_req_rdy = 100; p_inst_rdy = 100; p_commit = 100; max_delay = 0; p_stray = 0;
    p_err = 100;
    run(12);
    p_err = 0;

    // Reset while waiting for a response.
    do_reset(1);
    guard = 0;
    while (!pending && guard < 20) begin cycle(); guard++; end
    if (!pending) chk_fail("reach_wait_timeout", guard);
    do_reset(1);

    // Reset while waiting for a commit.
    p_commit = 0;
    guard = 0;
    while (!bus.commit_ready && guard < 20) begin cycle(); guard++; end
    if (!bus.commit_ready) chk_fail("reach_commit_timeout", guard);
    do_reset(1);

    // Long randomized run.
    p_req_rdy = 60; p_inst_rdy = 60; p_commit = 60; max_delay = 3; p_err = 3; p_stray = 20;
    run(3000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
